// File: rtl/uart_rx_core_if.sv
// -----------------------------------------------------------------------------
// uart_rx_core_if
// Receive-side output bundle of uart_rx_core, consumed by the UART RX FIFO and
// the MMIO UART slot.
//   rx_done_tick : one-clock strobe, frame complete and dout valid (FIFO write)
//   dout         : last received byte, held until the next frame completes
//   frame_err    : stop-bit sample of the last frame was 0
//   busy         : receiver is inside a frame (not IDLE)
// Modports: master = the receiver core, slave = the FIFO / slot side.
// -----------------------------------------------------------------------------
interface uart_rx_core_if #(
   parameter int DBIT = 8
);
   logic            rx_done_tick;
   logic [DBIT-1:0] dout;
   logic            frame_err;
   logic            busy;

   modport master (
      output rx_done_tick,
      output dout,
      output frame_err,
      output busy
   );

   modport slave (
      input rx_done_tick,
      input dout,
      input frame_err,
      input busy
   );
endinterface

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// Serial receive front end for the UART RX FIFO: rx pin synchronizer,
// programmable 16x-oversampling baud tick generator and the receive FSM.
// Emits one byte per frame (LSB first) with a one-clock done strobe.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   dvsr   : baud divisor, tick period = dvsr+1 clocks
//   rx     : asynchronous serial line, idle high
//   rx_if  : master side of uart_rx_core_if (rx_done_tick, dout, frame_err, busy)
// Parameters:
//   DBIT    : data bits per frame
//   SB_TICK : oversampling ticks per stop bit (16 = 1, 24 = 1.5, 32 = 2)
//   DVSR_W  : width of the baud divisor
// -----------------------------------------------------------------------------
module uart_rx_core #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int DVSR_W  = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DVSR_W-1:0] dvsr,
   input  logic              rx,
   uart_rx_core_if.master    rx_if
);

   // The sample counter must reach both 15 (data bits) and SB_TICK-1 (stop).
   localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
   localparam int S_W   = $clog2(S_MAX);
   localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [S_W-1:0] S_MID  = S_W'(7);
   localparam logic [S_W-1:0] S_LAST = S_W'(15);
   localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
   localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   // ---------------------------------------------------------------------------
   // rx synchronizer: the FSM only ever looks at rx_s.
   // ---------------------------------------------------------------------------
   logic rx_meta;
   logic rx_s;

   // NOTE: clocked state is always assigned with <= so every flop samples the
   // pre-edge value of its neighbours; = here would collapse the two stages.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // ---------------------------------------------------------------------------
   // Baud tick generator. The >= compare lets a smaller dvsr written mid-count
   // take effect at once instead of wrapping the whole counter range.
   // ---------------------------------------------------------------------------
   logic [DVSR_W-1:0] cnt_reg;
   logic [DVSR_W-1:0] cnt_next;
   logic              tick;
   logic              tick_clr;

   assign tick = (cnt_reg >= dvsr);

   always_comb begin
      cnt_next = cnt_reg + DVSR_W'(1);
      // tick_clr phase-aligns the sampling grid to the detected start edge.
      if (tick_clr || tick) begin
         cnt_next = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Receive FSM
   // ---------------------------------------------------------------------------
   state_t          state_reg,     state_next;
   logic [S_W-1:0]  s_reg,         s_next;
   logic [N_W-1:0]  n_reg,         n_next;
   logic [DBIT-1:0] shreg_reg,     shreg_next;
   logic [DBIT-1:0] dout_reg,      dout_next;
   logic            frame_err_reg, frame_err_next;
   logic            done_reg,      done_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         s_reg         <= '0;
         n_reg         <= '0;
         shreg_reg     <= '0;
         dout_reg      <= '0;
         frame_err_reg <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         s_reg         <= s_next;
         n_reg         <= n_next;
         shreg_reg     <= shreg_next;
         dout_reg      <= dout_next;
         frame_err_reg <= frame_err_next;
         done_reg      <= done_next;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default before the case, so no
      // path leaves a signal unassigned and no latch is inferred.
      state_next     = state_reg;
      s_next         = s_reg;
      n_next         = n_reg;
      shreg_next     = shreg_reg;
      dout_next      = dout_reg;
      frame_err_next = frame_err_reg;
      done_next      = 1'b0;
      tick_clr       = 1'b0;

      case (state_reg)
         IDLE: begin
            // No tick-dependent action here; only the start edge matters.
            if (!rx_s) begin
               state_next = START;
               s_next     = '0;
               tick_clr   = 1'b1;
            end
         end

         START: begin
            if (tick) begin
               if (s_reg == S_MID) begin
                  if (!rx_s) begin
                     state_next = DATA;
                     s_next     = '0;
                     n_next     = '0;
                  end else begin
                     // Line went back high before mid start bit: a glitch.
                     state_next = IDLE;
                  end
               end else begin
                  s_next = s_reg + S_W'(1);
               end
            end
         end

         DATA: begin
            if (tick) begin
               if (s_reg == S_LAST) begin
                  shreg_next = {rx_s, shreg_reg[DBIT-1:1]};
                  s_next     = '0;
                  if (n_reg == N_LAST) begin
                     state_next = STOP;
                  end else begin
                     n_next = n_reg + N_W'(1);
                  end
               end else begin
                  s_next = s_reg + S_W'(1);
               end
            end
         end

         STOP: begin
            if (tick) begin
               if (s_reg == S_STOP) begin
                  // Leaving at mid stop bit leaves half a bit of slack for an
                  // immediately following start edge. Errored frames are still
                  // delivered; the consumer decides what to do with them.
                  dout_next      = shreg_reg;
                  frame_err_next = ~rx_s;
                  done_next      = 1'b1;
                  state_next     = IDLE;
               end else begin
                  s_next = s_reg + S_W'(1);
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs. done_reg is registered alongside dout_reg so the strobe and the
   // new byte appear in the same clock.
   // ---------------------------------------------------------------------------
   assign rx_if.rx_done_tick = done_reg;
   assign rx_if.dout         = dout_reg;
   assign rx_if.frame_err    = frame_err_reg;
   assign rx_if.busy         = (state_reg != IDLE);

endmodule
